// File: rtl/bus_slave_sel_pkg.sv
// Shared definitions for the registered slave chip-select decoder.
package bus_slave_sel_pkg;

    // Active-low strobe/select levels
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Default geometry
    localparam int unsigned BUS_SEL_IDX_W   = 3;
    localparam int unsigned BUS_SEL_N_SLAVE = 8;
    localparam int unsigned BUS_SEL_TIMEOUT = 255;

    typedef enum logic [1:0] {
        BUS_SEL_IDLE   = 2'd0,
        BUS_SEL_ACCESS = 2'd1,
        BUS_SEL_RESP   = 2'd2
    } bus_sel_state_e;

    // Watchdog counter width; at least one bit so TIMEOUT = 0 still elaborates
    function automatic int unsigned cnt_width(int unsigned timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/bus_sel_wdog.sv
// Access watchdog: cleared at the start of an access, counts enabled cycles,
// flags expiry on the last permitted cycle. TIMEOUT = 0 never expires.
module bus_sel_wdog
    import bus_slave_sel_pkg::*;
#(
    parameter int unsigned TIMEOUT = BUS_SEL_TIMEOUT,
    parameter int unsigned CNT_W   = cnt_width(TIMEOUT)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned      LAST_INT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(LAST_INT);

    logic [CNT_W-1:0] count_q;

    // Cycle counter: clear has priority over increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expire = (TIMEOUT != 0) && (count_q == LAST);

endmodule

// File: rtl/bus_slave_sel.sv
// Registered slave chip-select decoder with unmapped-slave error and
// watchdog timeout. Holds the select until the slave answers, then returns
// a one-cycle active-low ready to the master.
module bus_slave_sel
    import bus_slave_sel_pkg::*;
#(
    parameter int unsigned         ADDR_W     = 30,
    parameter int unsigned         IDX_W      = BUS_SEL_IDX_W,
    parameter int unsigned         N_SLAVE    = BUS_SEL_N_SLAVE,
    parameter logic [N_SLAVE-1:0]  SLAVE_MASK = {N_SLAVE{1'b1}},
    parameter int unsigned         TIMEOUT    = BUS_SEL_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mAs_,
    input  logic [ADDR_W-1:0]  sAddr,
    input  logic [N_SLAVE-1:0] sRdy_,
    output logic [N_SLAVE-1:0] sCS_,
    output logic               mRdy_,
    output logic               mErr,
    output logic [IDX_W-1:0]   selIdx,
    output logic               busy
);

    localparam int unsigned IDX_SPAN = 2 ** IDX_W;
    // Mask widened to the full index space so out-of-range indices read as unmapped
    localparam logic [IDX_SPAN-1:0] MASK_EXT = IDX_SPAN'(SLAVE_MASK);

    bus_sel_state_e     state_q, state_d;
    logic [N_SLAVE-1:0] cs_q, cs_d;
    logic               rdy_q, rdy_d;
    logic               merr_q, merr_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   sel_q, sel_d;

    logic [IDX_W-1:0]    idx;
    logic                mapped;
    logic [IDX_SPAN-1:0] rdy_ext;
    logic                wd_clr, wd_en, wd_expire;
    logic                unused_addr;

    assign idx         = sAddr[ADDR_W-1 -: IDX_W];
    assign mapped      = MASK_EXT[idx];
    assign unused_addr = ^sAddr[ADDR_W-IDX_W-1:0];

    // Ready vector padded with idle-high bits up to the full index space
    always_comb begin
        rdy_ext = '1;
        rdy_ext[N_SLAVE-1:0] = sRdy_;
    end

    bus_sel_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        err_d   = err_q;
        sel_d   = sel_q;
        wd_clr  = 1'b0;
        wd_en   = 1'b0;
        // Ready/error pulse is a delayed image of the RESP state
        rdy_d   = (state_q == BUS_SEL_RESP) ? ENABLE_ : DISABLE_;
        merr_d  = (state_q == BUS_SEL_RESP) && err_q;

        unique case (state_q)
            BUS_SEL_IDLE: begin
                if (mAs_ == ENABLE_) begin
                    sel_d = idx;
                    if (mapped) begin
                        state_d = BUS_SEL_ACCESS;
                        err_d   = 1'b0;
                        wd_clr  = 1'b1;
                        for (int unsigned i = 0; i < N_SLAVE; i++) begin
                            cs_d[i] = (idx == IDX_W'(i)) ? ENABLE_ : DISABLE_;
                        end
                    end else begin
                        state_d = BUS_SEL_RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            BUS_SEL_ACCESS: begin
                // Ready beats a simultaneous timeout
                if (rdy_ext[sel_q] == ENABLE_) begin
                    cs_d    = '1;
                    state_d = BUS_SEL_RESP;
                    err_d   = 1'b0;
                end else if (wd_expire) begin
                    cs_d    = '1;
                    state_d = BUS_SEL_RESP;
                    err_d   = 1'b1;
                end else begin
                    wd_en = 1'b1;
                end
            end
            BUS_SEL_RESP: begin
                state_d = BUS_SEL_IDLE;
            end
            default: begin
                state_d = BUS_SEL_IDLE;
                cs_d    = '1;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BUS_SEL_IDLE;
            cs_q    <= '1;
            rdy_q   <= DISABLE_;
            merr_q  <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            rdy_q   <= rdy_d;
            merr_q  <= merr_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
        end
    end

    assign sCS_   = cs_q;
    assign mRdy_  = rdy_q;
    assign mErr   = merr_q;
    assign selIdx = sel_q;
    assign busy   = (state_q != BUS_SEL_IDLE);

endmodule

// File: tb/tb_bus_slave_sel.sv
// Directed bench for bus_slave_sel: dut_a has slave 7 unmapped and the
// default watchdog, dut_b has all slaves mapped and TIMEOUT = 4.
module tb_bus_slave_sel;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mas_a = 1'b1;
    logic        mas_b = 1'b1;
    logic [29:0] sAddr = '0;
    logic [7:0]  sRdy_ = 8'hFF;

    logic [7:0] cs_a, cs_b;
    logic       rdy_a, rdy_b, err_a, err_b, busy_a, busy_b;
    logic [2:0] sel_a, sel_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_slave_sel #(
        .SLAVE_MASK (8'h7F),
        .TIMEOUT    (255)
    ) dut_a (
        .clk    (clk),
        .reset  (reset),
        .mAs_   (mas_a),
        .sAddr  (sAddr),
        .sRdy_  (sRdy_),
        .sCS_   (cs_a),
        .mRdy_  (rdy_a),
        .mErr   (err_a),
        .selIdx (sel_a),
        .busy   (busy_a)
    );

    bus_slave_sel #(
        .TIMEOUT (4)
    ) dut_b (
        .clk    (clk),
        .reset  (reset),
        .mAs_   (mas_b),
        .sAddr  (sAddr),
        .sRdy_  (sRdy_),
        .sCS_   (cs_b),
        .mRdy_  (rdy_b),
        .mErr   (err_b),
        .selIdx (sel_b),
        .busy   (busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        #1;
        checks++;
        if ({cs_a, rdy_a, err_a, sel_a, busy_a} !== {8'hFF, 1'b1, 1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_a: got cs=%h rdy=%b err=%b sel=%0d busy=%b", cs_a, rdy_a, err_a,
                     sel_a, busy_a);
        end
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ({cs_a, rdy_a, busy_a, cs_b, rdy_b, busy_b} !== {8'hFF, 2'b10, 8'hFF, 2'b10}) begin
                errors++;
                $display("FAIL idle_%0d: got cs_a=%h rdy_a=%b busy_a=%b cs_b=%h rdy_b=%b busy_b=%b",
                         k, cs_a, rdy_a, busy_a, cs_b, rdy_b, busy_b);
            end
        end
    endtask

    task automatic test_normal();
        mas_a = 1'b0;
        sAddr = 30'h2000_0000;
        tick();
        mas_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            checks++;
            if ({cs_a, rdy_a, busy_a} !== {8'hEF, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL normal_cs_%0d: got cs=%h rdy=%b busy=%b want cs=ef rdy=1 busy=1",
                         k, cs_a, rdy_a, busy_a);
            end
        end
        sRdy_ = 8'hEF;
        tick();
        sRdy_ = 8'hFF;
        checks++;
        if ({cs_a, rdy_a, busy_a} !== {8'hFF, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL normal_release: got cs=%h rdy=%b busy=%b want ff 1 1", cs_a, rdy_a,
                     busy_a);
        end
        tick();
        checks++;
        if ({rdy_a, err_a, sel_a, busy_a} !== {1'b0, 1'b0, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL normal_resp: got rdy=%b err=%b sel=%0d busy=%b want 0 0 4 0", rdy_a,
                     err_a, sel_a, busy_a);
        end
        tick();
        checks++;
        if (rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL normal_pulse_end: got rdy=%b want 1", rdy_a);
        end
    endtask

    task automatic test_unmapped();
        mas_a = 1'b0;
        sAddr = 30'h3800_0000;
        tick();
        mas_a = 1'b1;
        checks++;
        if ({cs_a, rdy_a, sel_a, busy_a} !== {8'hFF, 1'b1, 3'd7, 1'b1}) begin
            errors++;
            $display("FAIL unmapped_e: got cs=%h rdy=%b sel=%0d busy=%b want ff 1 7 1", cs_a,
                     rdy_a, sel_a, busy_a);
        end
        tick();
        checks++;
        if ({cs_a, rdy_a, err_a, busy_a} !== {8'hFF, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL unmapped_resp: got cs=%h rdy=%b err=%b busy=%b want ff 0 1 0", cs_a,
                     rdy_a, err_a, busy_a);
        end
        tick();
        checks++;
        if ({rdy_a, err_a} !== 2'b10) begin
            errors++;
            $display("FAIL unmapped_end: got rdy=%b err=%b want 1 0", rdy_a, err_a);
        end
    endtask

    // ready_late: assert the selected ready in the 4th access cycle
    task automatic test_timeout(input bit ready_late);
        mas_b = 1'b0;
        sAddr = 30'h0800_0000;
        tick();
        mas_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            checks++;
            if ({cs_b, rdy_b} !== {8'hFD, 1'b1}) begin
                errors++;
                $display("FAIL timeout_cs_%0d_%0d: got cs=%h rdy=%b want fd 1", ready_late, k,
                         cs_b, rdy_b);
            end
            // Non-selected slave chatter must be ignored
            sRdy_ = (k % 2 == 0) ? 8'hFB : 8'hFF;
        end
        sRdy_ = ready_late ? 8'hFD : 8'hFF;
        tick();
        sRdy_ = 8'hFF;
        checks++;
        if ({cs_b, rdy_b, busy_b} !== {8'hFF, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL timeout_release_%0d: got cs=%h rdy=%b busy=%b want ff 1 1", ready_late,
                     cs_b, rdy_b, busy_b);
        end
        tick();
        checks++;
        if ({rdy_b, err_b, sel_b} !== {1'b0, !ready_late, 3'd1}) begin
            errors++;
            $display("FAIL timeout_resp_%0d: got rdy=%b err=%b sel=%0d want 0 %b 1", ready_late,
                     rdy_b, err_b, sel_b, !ready_late);
        end
        tick();
        checks++;
        if (rdy_b !== 1'b1) begin
            errors++;
            $display("FAIL timeout_end_%0d: got rdy=%b want 1", ready_late, rdy_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want_cs;
        sRdy_ = 8'h00;
        for (int n = 0; n < 3; n++) begin
            mas_a = 1'b0;
            sAddr = {3'(n), 27'h123_4567};
            tick();
            mas_a = 1'b1;
            want_cs = 8'hFF;
            want_cs[n] = 1'b0;
            checks++;
            if (cs_a !== want_cs) begin
                errors++;
                $display("FAIL b2b_cs_%0d: got cs=%h want %h", n, cs_a, want_cs);
            end
            tick();
            tick();
            checks++;
            if ({cs_a, rdy_a, err_a, sel_a, busy_a} !== {8'hFF, 1'b0, 1'b0, 3'(n), 1'b0}) begin
                errors++;
                $display("FAIL b2b_resp_%0d: got cs=%h rdy=%b err=%b sel=%0d busy=%b", n, cs_a,
                         rdy_a, err_a, sel_a, busy_a);
            end
        end
        sRdy_ = 8'hFF;
        tick();
    endtask

    task automatic test_reset_mid_access();
        bit seen_rdy;
        mas_a = 1'b0;
        sAddr = 30'h2000_0000;
        tick();
        mas_a = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({cs_a, busy_a} !== {8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got cs=%h busy=%b want ff 0", cs_a, busy_a);
        end
        tick();
        @(negedge clk);
        reset = 1'b0;
        seen_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (rdy_a == 1'b0) seen_rdy = 1'b1;
        end
        checks++;
        if (seen_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_pulse: got mRdy_ pulse=%b want 0", seen_rdy);
        end
        // Fresh access with an immediate answer completes in minimum latency
        mas_a = 1'b0;
        sAddr = 30'h1000_0000;
        tick();
        mas_a = 1'b1;
        sRdy_ = 8'hFB;
        checks++;
        if (cs_a !== 8'hFB) begin
            errors++;
            $display("FAIL post_reset_cs: got cs=%h want fb", cs_a);
        end
        tick();
        sRdy_ = 8'hFF;
        tick();
        checks++;
        if ({rdy_a, err_a, sel_a} !== {1'b0, 1'b0, 3'd2}) begin
            errors++;
            $display("FAIL post_reset_resp: got rdy=%b err=%b sel=%0d want 0 0 2", rdy_a, err_a,
                     sel_a);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_unmapped();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_back_to_back();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_slave_sel.md
Name: bus_slave_sel

Overview:
- Parametrised, registered successor to the combinational slave chip-select decoder.
- Decodes the slave index from the upper word-address bits and drives an active-low chip-select vector for N slaves.
- Holds the chip-select until the selected slave answers, then returns a one-cycle ready to the master.
- Adds an unmapped-slave error and a watchdog timeout. Sits between the bus master arbiter output and the slave ports.

Parameters:
- ADDR_W, 30: word address width.
- IDX_W, 3: slave index width; index = sAddr[ADDR_W-1 -: IDX_W].
- N_SLAVE, 8: number of slave ports, must be ≤ 2**IDX_W.
- SLAVE_MASK, {N_SLAVE{1'b1}}: bit i = 1 means slave i is mapped.
- TIMEOUT, 255: cycles to wait for slave ready; 0 = wait forever.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mAs_  in  1  master address strobe, active low, single-cycle request
- sAddr  in  ADDR_W  master word address, valid while mAs_ low
- sRdy_  in  N_SLAVE  per-slave ready, active low
- sCS_  out  N_SLAVE  per-slave chip select, active low, registered
- mRdy_  out  1  transfer complete to master, active low, registered, one-cycle pulse
- mErr  out  1  error qualifier, valid only while mRdy_ low
- selIdx  out  IDX_W  latched slave index, for the read-data mux
- busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high. All flops clear on reset assertion, independent of clk.
- Reset values: sCS_ all 1, mRdy_ = 1, mErr = 0, selIdx = 0, busy = 0, state = IDLE, counter = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, mAs_ sampled low:
  - Latch idx into selIdx.
  - If idx < N_SLAVE and SLAVE_MASK[idx] = 1: go to ACCESS, drive sCS_[idx] = 0 from the same edge, clear counter.
  - Otherwise: go to RESP with error set; no sCS_ asserted.
- IDLE, mAs_ high: no change.
- ACCESS, each edge:
  - If sRdy_[selIdx] = 0: sCS_ all 1, go to RESP with mErr = 0.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: sCS_ all 1, go to RESP with mErr = 1.
  - Else: counter += 1.
  - Ready and timeout in the same cycle: ready wins (mErr = 0).
- sRdy_ bits of non-selected slaves are ignored at all times.
- RESP: mRdy_ = 0 (and mErr as latched) for exactly one cycle, then IDLE. Outputs clear on leaving RESP.
- mAs_ is ignored in ACCESS and RESP. The master must not strobe while busy = 1.
- Latency:
  - mAs_ low sampled at edge E; sCS_ low after E.
  - Slave ready sampled at E+1 drives mRdy_ low during cycle E+2 to E+3.
  - Minimum request-to-mRdy_ latency is 2 cycles.
  - Back-to-back throughput: one transfer per 3 cycles.
- Counter width: $clog2(TIMEOUT+1); saturation is impossible by construction.
- sCS_ is one-hot-low or all-high; never more than one bit low.
- Reset asserted mid-ACCESS: sCS_ releases immediately (async). No mRdy_ pulse is generated for the aborted transfer.

Decomposition:
- Shared package/header bus.vh gains:
  - BUS_SEL_IDLE / BUS_SEL_ACCESS / BUS_SEL_RESP state encodings (2-bit).
  - Default IDX_W, N_SLAVE, TIMEOUT constants.
- Active-low ENABLE_/DISABLE_ values come from stddef.vh.
- One natural sub-module: bus_sel_wdog, the loadable timeout counter with clear, enable and expire outputs. Instantiate it once.
- The index decode stays inline.

Test Plan:
- Reset then idle: reset high 3 cycles, release → sCS_ = 8'hFF, mRdy_ = 1, busy = 0 for 10 cycles with mAs_ high.
- Normal access: mAs_ low, sAddr = 30'h2000_0000 (idx 4), sRdy_[4] low 3 cycles after sCS_[4] falls → sCS_ = 8'hEF for 4 cycles, then mRdy_ low for 1 cycle, mErr = 0, selIdx = 4.
- Unmapped slave: SLAVE_MASK = 8'h7F, access idx 7 → no sCS_ bit falls, mRdy_ low 1 cycle after E+1 with mErr = 1.
- Timeout: TIMEOUT = 4, access idx 1, sRdy_ held high → sCS_[1] low exactly 4 cycles, then mRdy_ low with mErr = 1. sRdy_[2] pulsing low meanwhile has no effect.
- Ready on the timeout cycle: TIMEOUT = 4, sRdy_[1] low in the 4th ACCESS cycle → mRdy_ low, mErr = 0.
- Reset mid-access: assert reset asynchronously 2 cycles into ACCESS → sCS_ goes to 8'hFF before the next clk edge. No mRdy_ pulse after release. A new access then completes normally.
